axi_sram_slave: RTL and testbench
=================================

Name: axi_sram_slave

Overview:
- AXI3-style responder that terminates the CPU's instruction/data AXI master port.
- Backs the port with a word-addressed on-chip memory; serves as the simulation and FPGA memory model behind the SRAM-to-AXI bridge.
- Independent read and write channels, one outstanding transaction per direction, INCR/FIXED bursts, byte strobes, SLVERR on out-of-range accesses.

Parameters:
- MEM_AW, 16, log2 of memory depth in 32-bit words (default 256 KB).
- BASE_ADDR, 32'h1c000000, byte address mapped to word 0.
- LFSR_SEED, 8'h5a, reset seed of the wait-state LFSR (used only with the optional feature).

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset, asynchronous, active-low
- arid  in  4  read ID
- araddr  in  32  read byte address
- arlen  in  8  beats-1
- arsize  in  3  log2 bytes per beat, ≤2
- arburst  in  2  00 FIXED, 01 INCR, others treated as INCR
- arlock/arcache/arprot  in  2/4/3  ignored
- arvalid  in  1  /  arready  out  1
- rid  out  4  /  rdata  out  32  /  rresp  out  2  /  rlast  out  1  /  rvalid  out  1  /  rready  in  1
- awid  in  4  /  awaddr  in  32  /  awlen  in  8  /  awsize  in  3  /  awburst  in  2
- awlock/awcache/awprot  in  2/4/3  ignored
- awvalid  in  1  /  awready  out  1
- wid  in  4  ignored  /  wdata  in  32  /  wstrb  in  4  /  wlast  in  1  /  wvalid  in  1  /  wready  out  1
- bid  out  4  /  bresp  out  2  /  bvalid  out  1  /  bready  in  1

Behaviour:
- Reset: aresetn is asynchronous and active-low. While it is low, all outputs are 0, both FSMs are IDLE, and memory contents are unaffected.
- arready and awready are registered. They rise the first cycle after reset release.
- Read FSM, states R_IDLE and R_DATA:
  - R_IDLE: arready=1. An AR handshake latches id, addr, len, size and burst, clears the beat counter, loads rdata from mem[idx(addr)], sets rvalid=1, and moves to R_DATA. Latency is AR handshake at cycle T, rvalid at T+1.
  - R_DATA: arready=0. rid, rdata, rresp and rlast are held stable while rvalid && !rready.
  - rlast = (beat_cnt == len).
  - R handshake with !rlast: addr += (1<<size) for INCR or stays the same for FIXED; beat_cnt++; the next beat loads in the same edge, so beats are back-to-back with no bubble.
  - R handshake with rlast: rvalid=0, return to R_IDLE. arready=1 on the following cycle.
- Write FSM, states W_IDLE, W_DATA and W_RESP:
  - W_IDLE: awready=1, wready=0. An AW handshake latches id, addr, len, size, burst and clears beat_cnt.
  - W_DATA: wready=1. On each W handshake, mem byte lanes with wstrb=1 are written at the clock edge, then addr and beat_cnt advance as on the read side.
  - W handshake with wlast: go to W_RESP with bvalid=1 and bid=latched id.
  - W_RESP: bvalid held until bready, then return to W_IDLE.
- Indexing: idx = (addr-BASE_ADDR)[MEM_AW+1:2]. An address is out of range when (addr-BASE_ADDR) ≥ 4<<MEM_AW.
- Out-of-range beats:
  - Reads return rdata=0 and rresp=2'b10 for that beat.
  - Writes are dropped. bresp=2'b10 if any beat of the burst was out of range.
- Burst length mismatch: if wlast arrives with beat_cnt≠len, or beat_cnt==len without wlast, bresp=2'b10. The burst still terminates only on wlast. Otherwise bresp=2'b00.
- Read/write collision: a write and a read beat load to the same word in the same cycle gives read-before-write; the read gets the old data.
- Channels run concurrently with no ordering between reads and writes.
- arsize>2 on the read side: beat is answered with SLVERR and rdata=0.
- arsize>2 on the write side: beat is dropped and bresp=SLVERR.
- Mid-burst reset: FSMs abort immediately. Already-written beats persist.

Optional Feature:
- Macro AXI_SLV_RAND_DELAY_EN.
- When defined, an 8-bit Fibonacci LFSR (taps 8,6,5,4, seeded LFSR_SEED at reset, steps every cycle) inserts wait states:
  - arready, awready and wready are additionally gated by lfsr[0].
  - Launch of each read beat (rvalid rise, including the first) is deferred until lfsr[1]=1.
  - bvalid rise is deferred until lfsr[2]=1.
  - AXI handshake stability rules are unchanged.
- When undefined: zero wait states and no LFSR logic.

Test Plan:
- Single read: preload mem[0]=32'h12345678; AR addr=32'h1c000000, len=0, id=3 at T → rvalid=1, rdata=32'h12345678, rid=3, rlast=1, rresp=0 at T+1; arready=1 at T+2.
- INCR read burst: preload words 4..7 = 1,2,3,4; AR addr=32'h1c000010, len=3, rready toggled 1,0,1,1,1 → beats 1,2,3,4 each held while stalled; rlast only on beat 4.
- Byte-strobe write: AW addr=32'h1c000008, len=0, id=5; W wdata=32'hAABBCCDD, wstrb=4'b0101, wlast=1 over old value 0 → mem word = 32'h00BB00DD; bvalid with bid=5, bresp=0; bready delayed 3 cycles keeps bvalid=1.
- Error paths: read addr=32'h1c000000+(4<<MEM_AW) → rresp=2'b10, rdata=0. Write len=1 with wlast on beat 0 → bresp=2'b10.
- Concurrency and collision: read and write of word 32'h1c000020 (old 32'h11, new 32'h22) in the same cycle → read returns 32'h11; a subsequent read returns 32'h22.
- Reset mid-burst: assert aresetn=0 during beat 2 of a len=3 read → rvalid=0 asynchronously; arready=1 one cycle after release; a new AR is served normally.

Source files
------------

// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI3-style slave backed by a word-addressed on-chip memory.
// Independent read and write channels, one outstanding burst per direction,
// INCR/FIXED bursts, byte strobes and SLVERR on out-of-range or oversize beats.
// Optional random wait states are compiled in with `define AXI_SLV_RAND_DELAY_EN.
module axi_sram_slave #(
    parameter int          MEM_AW    = 16,
    parameter logic [31:0] BASE_ADDR = 32'h1c000000,
    parameter logic [7:0]  LFSR_SEED = 8'h5a
) (
    input  logic        aclk,
    input  logic        aresetn,
    // read address
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic [1:0]  arlock,
    input  logic [3:0]  arcache,
    input  logic [2:0]  arprot,
    input  logic        arvalid,
    output logic        arready,
    // read data
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    // write address
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic [1:0]  awlock,
    input  logic [3:0]  awcache,
    input  logic [2:0]  awprot,
    input  logic        awvalid,
    output logic        awready,
    // write data
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    // write response
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam int         DEPTH  = 1 << MEM_AW;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;
    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    logic [31:0] mem [0:DEPTH-1];

    // Wait-state controls: constant "go" unless random delays are compiled in
    logic ready_gate;
    logic r_go;
    logic b_go;
    logic unused_ok;

    // Read channel state
    logic [0:0]        r_state_reg;
    logic              arready_reg;
    logic              rvalid_reg;
    logic [3:0]        rid_reg;
    logic [31:0]       rdata_reg;
    logic [1:0]        rresp_reg;
    logic              rlast_reg;
    logic [31:0]       r_addr_reg;
    logic [7:0]        r_len_reg;
    logic [2:0]        r_size_reg;
    logic [1:0]        r_burst_reg;
    logic [7:0]        r_beat_reg;
    logic [31:0]       r_addr_next;
    logic [31:0]       ld_addr;
    logic [2:0]        ld_size;
    logic [31:0]       ld_off;
    logic              ld_bad;
    logic [MEM_AW-1:0] ld_idx;
    logic              ar_hs;
    logic              r_hs;

    // Write channel state
    logic [1:0]        w_state_reg;
    logic              awready_reg;
    logic              wready_reg;
    logic              bvalid_reg;
    logic [3:0]        bid_reg;
    logic [1:0]        bresp_reg;
    logic [3:0]        w_id_reg;
    logic [31:0]       w_addr_reg;
    logic [7:0]        w_len_reg;
    logic [2:0]        w_size_reg;
    logic [1:0]        w_burst_reg;
    logic [7:0]        w_beat_reg;
    logic              w_err_reg;
    logic [31:0]       w_addr_next;
    logic [31:0]       w_off;
    logic              w_bad;
    logic              w_beat_err;
    logic [MEM_AW-1:0] w_idx;
    logic              aw_hs;
    logic              w_hs;
    logic              w_we;
    logic [3:0]        w_be;

`ifdef AXI_SLV_RAND_DELAY_EN
    logic [7:0] lfsr_reg;

    // 8-bit Fibonacci LFSR (taps 8,6,5,4) stepping every cycle
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            lfsr_reg <= LFSR_SEED;
        end else begin
            lfsr_reg <= {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};
        end
    end

    assign ready_gate = lfsr_reg[0];
    assign r_go       = lfsr_reg[1];
    assign b_go       = lfsr_reg[2];
    assign unused_ok  = &{1'b0, arlock, arcache, arprot, awlock, awcache, awprot, wid,
                          ld_off[1:0], w_off[1:0]};
`else
    assign ready_gate = 1'b1;
    assign r_go       = 1'b1;
    assign b_go       = 1'b1;
    assign unused_ok  = &{1'b0, arlock, arcache, arprot, awlock, awcache, awprot, wid,
                          ld_off[1:0], w_off[1:0], LFSR_SEED};
`endif

    assign arready = arready_reg & ready_gate;
    assign awready = awready_reg & ready_gate;
    assign wready  = wready_reg & ready_gate;
    assign rvalid  = rvalid_reg;
    assign rid     = rid_reg;
    assign rdata   = rdata_reg;
    assign rresp   = rresp_reg;
    assign rlast   = rlast_reg;
    assign bvalid  = bvalid_reg;
    assign bid     = bid_reg;
    assign bresp   = bresp_reg;

    assign ar_hs = arvalid & arready;
    assign r_hs  = rvalid_reg & rready;
    assign aw_hs = awvalid & awready;
    assign w_hs  = wvalid & wready;

    // Select the address of the read beat to load next and decode its range
    always_comb begin
        r_addr_next = (r_burst_reg == 2'b00) ? r_addr_reg : r_addr_reg + (32'd1 << r_size_reg);
        if (r_state_reg == R_IDLE) begin
            ld_addr = araddr;
            ld_size = arsize;
        end else if (rvalid_reg) begin
            ld_addr = r_addr_next;
            ld_size = r_size_reg;
        end else begin
            ld_addr = r_addr_reg;
            ld_size = r_size_reg;
        end
        ld_off = ld_addr - BASE_ADDR;
        ld_bad = (ld_off[31:MEM_AW+2] != '0) || (ld_size > 3'd2);
        ld_idx = ld_off[MEM_AW+1:2];
    end

    // Read FSM: latch AR, stream beats back-to-back, hold the beat while stalled
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state_reg <= R_IDLE;
            arready_reg <= 1'b0;
            rvalid_reg  <= 1'b0;
            rid_reg     <= '0;
            rdata_reg   <= '0;
            rresp_reg   <= OKAY;
            rlast_reg   <= 1'b0;
            r_addr_reg  <= '0;
            r_len_reg   <= '0;
            r_size_reg  <= '0;
            r_burst_reg <= '0;
            r_beat_reg  <= '0;
        end else begin
            case (r_state_reg)
                R_IDLE: begin
                    arready_reg <= 1'b1;
                    if (ar_hs) begin
                        arready_reg <= 1'b0;
                        r_state_reg <= R_DATA;
                        rid_reg     <= arid;
                        r_addr_reg  <= araddr;
                        r_len_reg   <= arlen;
                        r_size_reg  <= arsize;
                        r_burst_reg <= arburst;
                        r_beat_reg  <= '0;
                        rlast_reg   <= (arlen == 8'd0);
                        rvalid_reg  <= r_go;
                        if (r_go) begin
                            rdata_reg <= ld_bad ? 32'h0 : mem[ld_idx];
                            rresp_reg <= ld_bad ? SLVERR : OKAY;
                        end
                    end
                end
                default: begin
                    if (r_hs) begin
                        if (rlast_reg) begin
                            rvalid_reg  <= 1'b0;
                            rlast_reg   <= 1'b0;
                            arready_reg <= 1'b1;
                            r_state_reg <= R_IDLE;
                        end else begin
                            r_addr_reg <= r_addr_next;
                            r_beat_reg <= r_beat_reg + 8'd1;
                            rlast_reg  <= ((r_beat_reg + 8'd1) == r_len_reg);
                            rvalid_reg <= r_go;
                            if (r_go) begin
                                rdata_reg <= ld_bad ? 32'h0 : mem[ld_idx];
                                rresp_reg <= ld_bad ? SLVERR : OKAY;
                            end
                        end
                    end else if (!rvalid_reg && r_go) begin
                        // deferred beat launch (only reachable with wait states)
                        rvalid_reg <= 1'b1;
                        rdata_reg  <= ld_bad ? 32'h0 : mem[ld_idx];
                        rresp_reg  <= ld_bad ? SLVERR : OKAY;
                    end
                end
            endcase
        end
    end

    // Decode the current write beat: range, size and burst-length errors
    always_comb begin
        w_addr_next = (w_burst_reg == 2'b00) ? w_addr_reg : w_addr_reg + (32'd1 << w_size_reg);
        w_off       = w_addr_reg - BASE_ADDR;
        w_bad       = (w_off[31:MEM_AW+2] != '0) || (w_size_reg > 3'd2);
        w_idx       = w_off[MEM_AW+1:2];
        w_beat_err  = w_bad || (wlast != (w_beat_reg == w_len_reg));
        w_we        = w_hs && !w_bad && (w_state_reg == W_DATA);
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign w_be[gi] = w_we & wstrb[gi];
        end
    endgenerate

    // Memory write port with per-byte enables; contents survive reset
    always_ff @(posedge aclk) begin
        for (int i = 0; i < 4; i++) begin
            if (w_be[i]) begin
                mem[w_idx][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    // Write FSM: latch AW, accept beats until wlast, then hold B until accepted
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state_reg <= W_IDLE;
            awready_reg <= 1'b0;
            wready_reg  <= 1'b0;
            bvalid_reg  <= 1'b0;
            bid_reg     <= '0;
            bresp_reg   <= OKAY;
            w_id_reg    <= '0;
            w_addr_reg  <= '0;
            w_len_reg   <= '0;
            w_size_reg  <= '0;
            w_burst_reg <= '0;
            w_beat_reg  <= '0;
            w_err_reg   <= 1'b0;
        end else begin
            case (w_state_reg)
                W_IDLE: begin
                    awready_reg <= 1'b1;
                    if (aw_hs) begin
                        awready_reg <= 1'b0;
                        wready_reg  <= 1'b1;
                        w_id_reg    <= awid;
                        w_addr_reg  <= awaddr;
                        w_len_reg   <= awlen;
                        w_size_reg  <= awsize;
                        w_burst_reg <= awburst;
                        w_beat_reg  <= '0;
                        w_err_reg   <= 1'b0;
                        w_state_reg <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_hs) begin
                        if (wlast) begin
                            wready_reg  <= 1'b0;
                            bid_reg     <= w_id_reg;
                            bresp_reg   <= (w_err_reg || w_beat_err) ? SLVERR : OKAY;
                            bvalid_reg  <= b_go;
                            w_state_reg <= W_RESP;
                        end else begin
                            w_err_reg  <= w_err_reg | w_beat_err;
                            w_addr_reg <= w_addr_next;
                            w_beat_reg <= w_beat_reg + 8'd1;
                        end
                    end
                end
                W_RESP: begin
                    if (!bvalid_reg) begin
                        if (b_go) begin
                            bvalid_reg <= 1'b1;
                        end
                    end else if (bready) begin
                        bvalid_reg  <= 1'b0;
                        awready_reg <= 1'b1;
                        w_state_reg <= W_IDLE;
                    end
                end
                default: begin
                    w_state_reg <= W_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: directed and randomized checks of axi_sram_slave against
// a word-level memory model kept in the bench.
module tb_axi_sram_slave;

    localparam int          MEM_AW    = 16;
    localparam logic [31:0] BASE      = 32'h1c000000;
    localparam longint      MEM_BYTES = 64'd4 << MEM_AW;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [3:0]  arid = '0;
    logic [31:0] araddr = '0;
    logic [7:0]  arlen = '0;
    logic [2:0]  arsize = '0;
    logic [1:0]  arburst = '0;
    logic [1:0]  arlock = '0;
    logic [3:0]  arcache = '0;
    logic [2:0]  arprot = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [3:0]  awid = '0;
    logic [31:0] awaddr = '0;
    logic [7:0]  awlen = '0;
    logic [2:0]  awsize = '0;
    logic [1:0]  awburst = '0;
    logic [1:0]  awlock = '0;
    logic [3:0]  awcache = '0;
    logic [2:0]  awprot = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [3:0]  wid = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wlast = 1'b0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;

    always #5 aclk = ~aclk;

    axi_sram_slave #(.MEM_AW(MEM_AW), .BASE_ADDR(BASE), .LFSR_SEED(8'h5a)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    int          tests = 0;
    int          fails = 0;
    logic [31:0] model [int];
    logic [31:0] wd [0:255];
    logic [3:0]  ws [0:255];
    logic        rr_pat [0:15];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit is_oor(input logic [31:0] a, input logic [2:0] s);
        longint off;
        off = longint'(a) - longint'(BASE);
        return (off < 0) || (off >= MEM_BYTES) || (s > 3'd2);
    endfunction

    function automatic int word_key(input logic [31:0] a);
        return int'((longint'(a) - longint'(BASE)) / 4);
    endfunction

    function automatic logic [31:0] step_addr(input logic [31:0] a, input logic [2:0] s, input logic [1:0] bu);
        return (bu == 2'b00) ? a : a + (32'd1 << s);
    endfunction

    function automatic logic [31:0] exp_data(input logic [31:0] a, input logic [2:0] s);
        int k;
        if (is_oor(a, s)) return 32'h0;
        k = word_key(a);
        return model.exists(k) ? model[k] : 32'h0;
    endfunction

    // Full write transaction: AW, nbeats W beats (wlast on the final one), B after bdelay stall cycles
    task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [3:0] id, input int nbeats, input int bdelay);
        logic [31:0] a;
        logic [31:0] w;
        bit          err;
        bit          hs;
        int          n;
        int          k;
        a   = addr;
        err = (nbeats != int'(len) + 1);
        for (int b = 0; b < nbeats; b++) begin
            if (is_oor(a, size)) begin
                err = 1'b1;
            end else begin
                k = word_key(a);
                w = model.exists(k) ? model[k] : 32'h0;
                for (int i = 0; i < 4; i++) if (ws[b][i]) w[i*8 +: 8] = wd[b][i*8 +: 8];
                model[k] = w;
            end
            a = step_addr(a, size, burst);
        end
        awaddr = addr; awlen = len; awsize = size; awburst = burst; awid = id; awvalid = 1'b1;
        n = 0;
        do begin hs = awready; @(posedge aclk); #1; n++; end while (!hs && n < 100);
        awvalid = 1'b0;
        check("aw_handshake", 32'(hs), 32'd1);
        for (int b = 0; b < nbeats; b++) begin
            wdata = wd[b]; wstrb = ws[b]; wlast = (b == nbeats - 1); wvalid = 1'b1;
            n = 0;
            do begin hs = wready; @(posedge aclk); #1; n++; end while (!hs && n < 100);
            check("w_handshake", 32'(hs), 32'd1);
        end
        wvalid = 1'b0; wlast = 1'b0;
        n = 0;
        while (!bvalid && n < 100) begin @(posedge aclk); #1; n++; end
        check("bvalid_seen", 32'(bvalid), 32'd1);
        for (int c = 0; c < bdelay; c++) begin
            @(posedge aclk); #1;
            check("bvalid_hold", 32'(bvalid), 32'd1);
        end
        check("bresp", 32'(bresp), err ? 32'd2 : 32'd0);
        check("bid", 32'(bid), 32'(id));
        bready = 1'b1;
        @(posedge aclk); #1;
        bready = 1'b0;
        check("bvalid_drop", 32'(bvalid), 32'd0);
        check("awready_back", 32'(awready), 32'd1);
        $display("[TB] write addr=%h len=%0d size=%0d burst=%0d id=%0d beats=%0d bresp=%0d",
                 addr, len, size, burst, id, nbeats, bresp);
    endtask

    // Full read transaction; mode 0 rready high, 1 random rready, 2 rr_pat sequence
    task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [3:0] id, input int mode);
        logic [31:0] a;
        bit          hs;
        bit          done;
        int          n;
        int          cyc;
        araddr = addr; arlen = len; arsize = size; arburst = burst; arid = id; arvalid = 1'b1;
        n = 0;
        do begin hs = arready; @(posedge aclk); #1; n++; end while (!hs && n < 100);
        arvalid = 1'b0;
        check("ar_handshake", 32'(hs), 32'd1);
        check("rvalid_latency", 32'(rvalid), 32'd1);
        a   = addr;
        cyc = 0;
        for (int b = 0; b <= int'(len); b++) begin
            done = 1'b0;
            while (!done && cyc < 1000) begin
                if (mode == 0)      rready = 1'b1;
                else if (mode == 1) rready = 1'($urandom_range(0, 1));
                else                rready = rr_pat[cyc % 16];
                cyc++;
                check("rvalid", 32'(rvalid), 32'd1);
                check("rdata", rdata, exp_data(a, size));
                check("rresp", 32'(rresp), is_oor(a, size) ? 32'd2 : 32'd0);
                check("rid", 32'(rid), 32'(id));
                check("rlast", 32'(rlast), (b == int'(len)) ? 32'd1 : 32'd0);
                done = rready;
                @(posedge aclk); #1;
            end
            a = step_addr(a, size, burst);
        end
        rready = 1'b0;
        check("rvalid_end", 32'(rvalid), 32'd0);
        check("arready_back", 32'(arready), 32'd1);
        $display("[TB] read addr=%h len=%0d size=%0d burst=%0d id=%0d cycles=%0d",
                 addr, len, size, burst, id, cyc);
    endtask

    initial begin
        bit hs;
        int n;

        // reset state
        repeat (3) @(posedge aclk);
        #1;
        check("rst_arready", 32'(arready), 32'd0);
        check("rst_awready", 32'(awready), 32'd0);
        check("rst_wready", 32'(wready), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_rlast", 32'(rlast), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_bvalid", 32'(bvalid), 32'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk); #1;
        check("rel_arready", 32'(arready), 32'd1);
        check("rel_awready", 32'(awready), 32'd1);
        $display("[TB] reset released");

        // preload words 0..63 with random data
        for (int b = 0; b < 64; b++) begin wd[b] = $urandom; ws[b] = 4'hf; end
        do_write(BASE, 8'd63, 3'd2, 2'b01, 4'd0, 64, 0);

        // single read
        wd[0] = 32'h12345678; ws[0] = 4'hf;
        do_write(BASE, 8'd0, 3'd2, 2'b01, 4'd1, 1, 0);
        do_read(BASE, 8'd0, 3'd2, 2'b01, 4'd3, 0);

        // INCR burst with rready 1,0,1,1,1
        for (int b = 0; b < 4; b++) begin wd[b] = 32'(b + 1); ws[b] = 4'hf; end
        do_write(BASE + 32'h10, 8'd3, 3'd2, 2'b01, 4'd2, 4, 0);
        for (int i = 0; i < 16; i++) rr_pat[i] = 1'b1;
        rr_pat[1] = 1'b0;
        do_read(BASE + 32'h10, 8'd3, 3'd2, 2'b01, 4'd4, 2);

        // byte strobes over zero, delayed bready
        wd[0] = 32'h0; ws[0] = 4'hf;
        do_write(BASE + 32'h8, 8'd0, 3'd2, 2'b01, 4'd5, 1, 0);
        wd[0] = 32'hAABBCCDD; ws[0] = 4'b0101;
        do_write(BASE + 32'h8, 8'd0, 3'd2, 2'b01, 4'd5, 1, 3);
        araddr = BASE + 32'h8; arlen = 0; arsize = 2; arburst = 1; arid = 5; arvalid = 1'b1;
        @(posedge aclk); #1;
        arvalid = 1'b0;
        check("strobe_word", rdata, 32'h00BB00DD);
        rready = 1'b1; @(posedge aclk); #1; rready = 1'b0;
        $display("[TB] read strobe word=%h", 32'h00BB00DD);

        // error paths
        do_read(BASE + 32'(MEM_BYTES), 8'd0, 3'd2, 2'b01, 4'd6, 0);
        do_read(BASE + 32'h40, 8'd1, 3'd3, 2'b01, 4'd7, 0);
        wd[0] = 32'h0BADF00D; ws[0] = 4'hf;
        do_write(BASE + 32'h30, 8'd1, 3'd2, 2'b01, 4'd8, 1, 0);
        wd[0] = 32'hDEADBEEF; ws[0] = 4'hf;
        do_write(BASE + 32'h28, 8'd0, 3'd3, 2'b01, 4'd9, 1, 0);
        do_read(BASE + 32'h28, 8'd1, 3'd2, 2'b01, 4'd9, 0);
        for (int b = 0; b < 3; b++) begin wd[b] = $urandom; ws[b] = 4'hf; end
        do_write(BASE + 32'h50, 8'd1, 3'd2, 2'b01, 4'd10, 3, 1);
        for (int b = 0; b < 4; b++) begin wd[b] = $urandom; ws[b] = 4'hf; end
        do_write(BASE + 32'(MEM_BYTES) - 32'd8, 8'd3, 3'd2, 2'b01, 4'd11, 4, 0);
        do_read(BASE + 32'(MEM_BYTES) - 32'd8, 8'd3, 3'd2, 2'b01, 4'd11, 1);

        // read/write collision on one word
        wd[0] = 32'h11; ws[0] = 4'hf;
        do_write(BASE + 32'h20, 8'd0, 3'd2, 2'b01, 4'd1, 1, 0);
        awaddr = BASE + 32'h20; awlen = 0; awsize = 2; awburst = 1; awid = 4'd12; awvalid = 1'b1;
        n = 0;
        do begin hs = awready; @(posedge aclk); #1; n++; end while (!hs && n < 100);
        awvalid = 1'b0;
        check("coll_aw_handshake", 32'(hs), 32'd1);
        araddr = BASE + 32'h20; arlen = 0; arsize = 2; arburst = 1; arid = 4'd13; arvalid = 1'b1;
        wdata = 32'h22; wstrb = 4'hf; wlast = 1'b1; wvalid = 1'b1;
        check("coll_arready", 32'(arready), 32'd1);
        check("coll_wready", 32'(wready), 32'd1);
        @(posedge aclk); #1;
        arvalid = 1'b0; wvalid = 1'b0; wlast = 1'b0;
        check("coll_rvalid", 32'(rvalid), 32'd1);
        check("coll_rdata_old", rdata, 32'h11);
        model[8] = 32'h22;
        rready = 1'b1; @(posedge aclk); #1; rready = 1'b0;
        check("coll_bvalid", 32'(bvalid), 32'd1);
        check("coll_bresp", 32'(bresp), 32'd0);
        bready = 1'b1; @(posedge aclk); #1; bready = 1'b0;
        $display("[TB] collision word=%h old=%h", BASE + 32'h20, 32'h11);
        do_read(BASE + 32'h20, 8'd0, 3'd2, 2'b01, 4'd14, 0);

        // reset during beat 2 of a len=3 read
        araddr = BASE + 32'h10; arlen = 3; arsize = 2; arburst = 1; arid = 4'd15; arvalid = 1'b1;
        @(posedge aclk); #1;
        arvalid = 1'b0; rready = 1'b1;
        @(posedge aclk); #1;
        @(posedge aclk); #1;
        check("mid_beat2_data", rdata, exp_data(BASE + 32'h18, 3'd2));
        #2 aresetn = 1'b0;
        #1;
        check("mid_rst_rvalid", 32'(rvalid), 32'd0);
        check("mid_rst_arready", 32'(arready), 32'd0);
        rready = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk); #1;
        check("mid_rel_arready", 32'(arready), 32'd1);
        $display("[TB] reset during read burst");
        do_read(BASE + 32'h10, 8'd3, 3'd2, 2'b01, 4'd2, 0);

        // randomized traffic inside the preloaded region
        for (int t = 0; t < 24; t++) begin
            logic [31:0] a;
            logic [7:0]  l;
            logic [2:0]  s;
            logic [1:0]  bu;
            a  = BASE + 32'($urandom_range(0, 48)) * 32'd4;
            l  = 8'($urandom_range(0, 7));
            s  = 3'($urandom_range(0, 2));
            bu = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b01;
            if (t % 2 == 0) begin
                for (int b = 0; b <= int'(l); b++) begin wd[b] = $urandom; ws[b] = 4'($urandom); end
                do_write(a, l, s, bu, 4'($urandom), int'(l) + 1, int'($urandom_range(0, 2)));
            end else begin
                do_read(a, l, s, bu, 4'($urandom), 1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
